maze_path_stack: RTL and testbench

- Move stack and path replayer for the maze solver datapath.
- During search, it is the LIFO the datapath pushes moves onto. On `pop` (back-tracking) it returns the top move, which the direction counter reloads.
- Once the solver reports `found`, a `start` pulse replays the recorded path from the first move to the last. Each step is output as a move plus the resulting X/Y coordinate, over a valid/ready handshake to the downstream result/display stage.

---
 rtl/maze_path_stack_pkg.sv | 44 ++++
 rtl/maze_path_stack_if.sv | 40 ++++
 rtl/maze_path_stack_move_lifo.sv | 81 ++++++++
 rtl/maze_path_stack.sv | 140 ++++++++++++++
 tb/tb_maze_path_stack.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/maze_path_stack_pkg.sv
// Shared move codes, FSM states, coordinate type and the move-application helper
// used by the maze solver path stack.
package maze_path_stack_pkg;

  localparam int MAZE_DIM = 16;
  localparam int DEPTH    = MAZE_DIM * MAZE_DIM;
  localparam int MOVE_W   = 2;
  localparam int COORD_W  = $clog2(MAZE_DIM);
  localparam int PTR_W    = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    MOVE_UP    = 2'd0,
    MOVE_RIGHT = 2'd1,
    MOVE_LEFT  = 2'd2,
    MOVE_DOWN  = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    ST_RECORD = 2'd0,
    ST_PLAY   = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  // Coordinates wrap modulo 2^COORD_W; leaving the maze is not flagged here.
  function automatic pos_t apply_move(pos_t p, logic [MOVE_W-1:0] m);
    pos_t r;
    r = p;
    case (move_e'(m))
      MOVE_UP:    r.y = p.y - coord_t'(1);
      MOVE_RIGHT: r.x = p.x + coord_t'(1);
      MOVE_LEFT:  r.x = p.x - coord_t'(1);
      MOVE_DOWN:  r.y = p.y + coord_t'(1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/maze_path_stack_if.sv
// Command, status and playback-step bundle between the solver datapath and the path stack.
// The stack side uses the slave modport; the datapath/consumer side uses master.
interface maze_path_stack_if
  import maze_path_stack_pkg::*;
#(
  parameter int P_MOVE_W  = MOVE_W,
  parameter int P_COORD_W = COORD_W,
  parameter int P_PTR_W   = PTR_W
) ();

  logic                 clear;
  logic                 push;
  logic                 pop;
  logic [P_MOVE_W-1:0]  move_in;
  logic [P_MOVE_W-1:0]  top_move;
  logic                 empty;
  logic                 full;
  logic [P_PTR_W-1:0]   depth;
  logic                 overflow_err;
  logic                 start;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_MOVE_W-1:0]  out_move;
  logic [P_COORD_W-1:0] out_x;
  logic [P_COORD_W-1:0] out_y;
  logic                 done;

  modport slave (
    input  clear, push, pop, move_in, start, out_ready,
    output top_move, empty, full, depth, overflow_err,
    output out_valid, out_move, out_x, out_y, done
  );

  modport master (
    output clear, push, pop, move_in, start, out_ready,
    input  top_move, empty, full, depth, overflow_err,
    input  out_valid, out_move, out_x, out_y, done
  );

endinterface

// File: rtl/maze_path_stack_move_lifo.sv
// Register-array move stack: push / pop / replace-top, combinational top and random-access read.
// Single-cycle update; never stalls, a push while full is dropped and latches overflow_err.
module move_lifo #(
  parameter int DEPTH = 256,
  parameter int W     = 2,
  parameter int PTR_W = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdat,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [W-1:0]               top_dat,
  output logic [W-1:0]               rd_dat,
  output logic [PTR_W-1:0]           sp,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow_err
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_addr;

  assign empty    = (sp_q == '0);
  assign full     = (sp_q == PTR_W'(DEPTH));
  // At sp==DEPTH the low bits are zero, so the decrement lands on the last entry.
  assign top_addr = sp_q[AW-1:0] - AW'(1);

  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = sp_q[AW-1:0];
    if (clr) begin
      sp_d  = '0;
      ovf_d = 1'b0;
    end else if (push && (!pop || empty)) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + PTR_W'(1);
      end
    end else if (push && pop) begin
      wr_en   = 1'b1;
      wr_addr = top_addr;
    end else if (pop && !empty) begin
      sp_d = sp_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wdat;
    end
  end

  assign top_dat      = empty ? '0 : mem_q[top_addr];
  assign rd_dat       = mem_q[rd_addr];
  assign sp           = sp_q;
  assign overflow_err = ovf_q;

endmodule

// File: rtl/maze_path_stack.sv
// Maze move stack with in-order path replay as (move, x, y) steps from origin (0,0).
// First step valid 1 cycle after start, one step/cycle; out_ready low stalls with stable outputs.
module maze_path_stack
  import maze_path_stack_pkg::*;
#(
  parameter int P_DEPTH   = DEPTH,
  parameter int P_MOVE_W  = MOVE_W,
  parameter int P_COORD_W = COORD_W,
  parameter int P_PTR_W   = PTR_W
) (
  input logic              clk,
  input logic              rst,
  maze_path_stack_if.slave io
);

  localparam int AW = $clog2(P_DEPTH);

  state_e               state_q, state_d;
  logic [P_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  pos_t                 pos_q, pos_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;

  logic                 in_record;
  logic                 in_play;
  logic                 lifo_push;
  logic                 lifo_pop;
  logic                 lifo_empty;
  logic [P_MOVE_W-1:0]  rd_dat;
  logic [P_PTR_W-1:0]   sp;
  logic                 accept;
  logic                 last_step;
  pos_t                 step;

  assign in_record = (state_q == ST_RECORD);
  assign in_play   = (state_q == ST_PLAY);

  // Stack edits are only honoured while recording and never alongside start.
  assign lifo_push = in_record & io.push & ~io.start;
  assign lifo_pop  = in_record & io.pop  & ~io.start;

  move_lifo #(
    .DEPTH (P_DEPTH),
    .W     (P_MOVE_W),
    .PTR_W (P_PTR_W)
  ) u_lifo (
    .clk          (clk),
    .rst          (rst),
    .clr          (io.clear),
    .push         (lifo_push),
    .pop          (lifo_pop),
    .wdat         (io.move_in),
    .rd_addr      (rd_ptr_q[AW-1:0]),
    .top_dat      (io.top_move),
    .rd_dat       (rd_dat),
    .sp           (sp),
    .full         (io.full),
    .empty        (lifo_empty),
    .overflow_err (io.overflow_err)
  );

  assign step      = apply_move(pos_q, rd_dat);
  assign accept    = out_valid_q & io.out_ready;
  assign last_step = ((rd_ptr_q + P_PTR_W'(1)) == sp);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    if (io.clear) begin
      state_d     = ST_RECORD;
      rd_ptr_d    = '0;
      pos_d       = '0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_RECORD: begin
          if (io.start) begin
            rd_ptr_d = '0;
            pos_d    = '0;
            if (lifo_empty) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d     = ST_PLAY;
              out_valid_d = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (accept) begin
            pos_d    = step;
            rd_ptr_d = rd_ptr_q + P_PTR_W'(1);
            if (last_step) begin
              state_d     = ST_DONE;
              out_valid_d = 1'b0;
              done_d      = 1'b1;
            end
          end
        end
        ST_DONE: begin
        end
        default: begin
          state_d     = ST_RECORD;
          out_valid_d = 1'b0;
          done_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RECORD;
      rd_ptr_q    <= '0;
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  // Outside PLAY the outputs show the held position with the move as a no-op.
  assign io.out_valid = out_valid_q;
  assign io.done      = done_q;
  assign io.out_move  = in_play ? rd_dat : '0;
  assign io.out_x     = in_play ? step.x : pos_q.x;
  assign io.out_y     = in_play ? step.y : pos_q.y;
  assign io.empty     = lifo_empty;
  assign io.depth     = sp;

endmodule

// File: tb/tb_maze_path_stack.sv
// Directed and randomized checks of maze_path_stack against a queue-based path model.
module tb_maze_path_stack;
  import maze_path_stack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maze_path_stack_if bus ();

  maze_path_stack dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: recorded path as a queue, playback cursor and position as plain ints.
  int stk[$];
  bit m_ovf, m_play, m_done;
  int m_idx, m_x, m_y;

  function automatic int dx(int m);
    return (m == 1) ? 1 : ((m == 2) ? -1 : 0);
  endfunction

  function automatic int dy(int m);
    return (m == 0) ? -1 : ((m == 3) ? 1 : 0);
  endfunction

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    stk.delete();
    m_ovf  = 0;
    m_play = 0;
    m_done = 0;
    m_idx  = 0;
    m_x    = 0;
    m_y    = 0;
  endtask

  task automatic check_all();
    int n;
    n = stk.size();
    chk("depth", int'(bus.depth), n);
    chk("empty", int'(bus.empty), int'(n == 0));
    chk("full", int'(bus.full), int'(n == DEPTH));
    chk("top_move", int'(bus.top_move), (n > 0) ? stk[n-1] : 0);
    chk("overflow_err", int'(bus.overflow_err), int'(m_ovf));
    chk("out_valid", int'(bus.out_valid), int'(m_play));
    chk("done", int'(bus.done), int'(m_done));
    if (m_play) begin
      chk("out_move", int'(bus.out_move), stk[m_idx]);
      chk("out_x", int'(bus.out_x), (m_x + dx(stk[m_idx])) & 15);
      chk("out_y", int'(bus.out_y), (m_y + dy(stk[m_idx])) & 15);
    end else begin
      chk("hold_x", int'(bus.out_x), m_x);
      chk("hold_y", int'(bus.out_y), m_y);
    end
  endtask

  task automatic model_step(bit clr, bit ps, bit pp, int mv, bit st, bit rdy);
    if (clr) begin
      model_clear();
    end else if (m_play) begin
      if (rdy) begin
        m_x = (m_x + dx(stk[m_idx])) & 15;
        m_y = (m_y + dy(stk[m_idx])) & 15;
        m_idx++;
        if (m_idx == stk.size()) begin
          m_play = 0;
          m_done = 1;
        end
      end
    end else if (!m_done) begin
      if (st) begin
        if (stk.size() == 0) m_done = 1;
        else begin
          m_play = 1;
          m_idx  = 0;
          m_x    = 0;
          m_y    = 0;
        end
      end else if (ps && (!pp || stk.size() == 0)) begin
        if (stk.size() == DEPTH) m_ovf = 1;
        else stk.push_back(mv);
      end else if (ps && pp) begin
        stk[stk.size()-1] = mv;
      end else if (pp && stk.size() > 0) begin
        void'(stk.pop_back());
      end
    end
  endtask

  // Drive at posedge+1, check at negedge, advance the model for the coming edge.
  task automatic cyc(bit clr, bit ps, bit pp, int mv, bit st, bit rdy);
    bus.clear     = clr;
    bus.push      = ps;
    bus.pop       = pp;
    bus.move_in   = 2'(mv);
    bus.start     = st;
    bus.out_ready = rdy;
    @(negedge clk);
    check_all();
    model_step(clr, ps, pp, mv, st, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic push_mv(int mv);
    cyc(0, 1, 0, mv, 0, 0);
  endtask

  task automatic do_clear();
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic play_out(bit rand_ready);
    int budget;
    budget = 0;
    while (m_play && budget < 2000) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      budget++;
    end
    if (m_play) chk("play_timeout", 1, 0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.move_in   = '0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Path 1,1,3,3 replayed with the consumer always ready.
    push_mv(1); push_mv(1); push_mv(3); push_mv(3);
    cyc(0, 0, 0, 0, 1, 1);
    play_out(0);
    chk("p1_done", int'(bus.done), 1);
    chk("p1_x", int'(bus.out_x), 2);
    chk("p1_y", int'(bus.out_y), 2);
    cyc(0, 1, 0, 2, 0, 0);

    // Pop then push rewrites the path tail.
    do_clear();
    push_mv(1); push_mv(3); push_mv(2);
    cyc(0, 0, 1, 0, 0, 0);
    push_mv(3);
    chk("p2_depth", int'(bus.depth), 3);
    chk("p2_top", int'(bus.top_move), 3);
    cyc(0, 0, 0, 0, 1, 1);
    play_out(0);
    chk("p2_x", int'(bus.out_x), 1);
    chk("p2_y", int'(bus.out_y), 2);

    // Replace-top and pop on empty.
    do_clear();
    push_mv(1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("rep_depth", int'(bus.depth), 1);
    chk("rep_top", int'(bus.top_move), 0);
    do_clear();
    cyc(0, 0, 1, 0, 0, 0);
    chk("pop_empty_depth", int'(bus.depth), 0);
    chk("pop_empty_ovf", int'(bus.overflow_err), 0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < DEPTH; i++) push_mv(int'($urandom_range(0, 3)));
    chk("fill_full", int'(bus.full), 1);
    chk("fill_depth", int'(bus.depth), 256);
    push_mv(int'($urandom_range(0, 3)));
    chk("ovf_set", int'(bus.overflow_err), 1);
    do_clear();
    chk("clr_empty", int'(bus.empty), 1);
    chk("clr_ovf", int'(bus.overflow_err), 0);

    // Single LEFT step under backpressure wraps X to 15.
    push_mv(2);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("left_done", int'(bus.done), 1);
    chk("left_x", int'(bus.out_x), 15);

    // Start on an empty stack.
    do_clear();
    cyc(0, 0, 0, 0, 1, 1);
    chk("empty_start_done", int'(bus.done), 1);
    chk("empty_start_vld", int'(bus.out_valid), 0);
    cyc(0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of playback.
    do_clear();
    push_mv(1); push_mv(3); push_mv(3);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_vld", int'(bus.out_valid), 0);
    chk("arst_depth", int'(bus.depth), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);

    // Randomized record / replay rounds.
    for (int r = 0; r < 20; r++) begin
      int nops;
      do_clear();
      nops = int'($urandom_range(0, 40));
      for (int k = 0; k < nops; k++) begin
        int op;
        op = int'($urandom_range(0, 3));
        cyc(0, op != 1, op == 1 || op == 2, int'($urandom_range(0, 3)), 0, 0);
      end
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1,
          1'($urandom_range(0, 1)));
      play_out(1);
      cyc(0, 1, 0, int'($urandom_range(0, 3)), 1, 1);
      cyc(0, 0, 1, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
